// File: rtl/conv_pkg.sv
// Shared constants, FSM state encoding and compare helper for the conv/pool pipeline.
package conv_pkg;

  localparam int unsigned DW    = 13;
  localparam int unsigned AW    = 12;
  localparam int unsigned IMG_W = 64;
  localparam int unsigned OW    = $clog2(IMG_W / 2);

  localparam logic CSEL_L0 = 1'b0;
  localparam logic CSEL_L1 = 1'b1;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_RD0   = 3'd1;
  localparam state_t S_RD1   = 3'd2;
  localparam state_t S_RD2   = 3'd3;
  localparam state_t S_RD3   = 3'd4;
  localparam state_t S_FLUSH = 3'd5;
  localparam state_t S_WRITE = 3'd6;
  localparam state_t S_DONE  = 3'd7;

  // Unsigned max; on a tie the first operand (the running max) is kept.
  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/maxpool2x2_if.sv
// Control handshake plus the shared csel-switched layer buffer port.
interface maxpool2x2_if;
  import conv_pkg::*;

  logic          start;
  logic          busy;
  logic          done;
  logic          crd;
  logic [AW-1:0] caddr_rd;
  logic [DW-1:0] cdata_rd;
  logic          cwr;
  logic [AW-1:0] caddr_wr;
  logic [DW-1:0] cdata_wr;
  logic          csel;

  modport master (
    input  start, cdata_rd,
    output busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

  modport slave (
    output start, cdata_rd,
    input  busy, done, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
  );

endinterface

// File: rtl/maxpool2x2_max_acc.sv
// Running-max register: load on the first tap, unsigned compare on later taps.
module max_acc
  import conv_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_load,
  input  logic          en,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] max
);

  logic [DW-1:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    if (en) max_d = clr_load ? din : umax(max_q, din);
  end

  always_ff @(posedge clk) begin
    if (reset) max_q <= '0;
    else       max_q <= max_d;
  end

  assign max = max_q;

endmodule

// File: rtl/maxpool2x2.sv
// 2x2 stride-2 max-pool from layer-0 buffer into layer-1 buffer; six cycles per output.
module maxpool2x2
  import conv_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  maxpool2x2_if.master bus
);

  localparam logic [OW-1:0] LAST = OW'(IMG_W / 2 - 1);

  state_t        state_q, state_d;
  logic [OW-1:0] r_q, r_d, c_q, c_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          crd_q, crd_d, cwr_q, cwr_d, csel_q, csel_d;
  logic [AW-1:0] caddr_rd_q, caddr_rd_d, caddr_wr_q, caddr_wr_d;
  logic [DW-1:0] cdata_wr_q, cdata_wr_d;
  logic [1:0]    tap_d;
  logic          acc_en_c, acc_load_c;
  logic [DW-1:0] acc_max;

  // Read data lags the address by one edge, so tap k-1 lands while in READ k (tap 3 in FLUSH).
  assign acc_en_c   = (state_q >= S_RD1) && (state_q <= S_FLUSH);
  assign acc_load_c = (state_q == S_RD1);

  max_acc u_max_acc (
    .clk      (clk),
    .reset    (reset),
    .clr_load (acc_load_c),
    .en       (acc_en_c),
    .din      (bus.cdata_rd),
    .max      (acc_max)
  );

  // Next state and output-pixel counters.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RD0;
          r_d     = '0;
          c_d     = '0;
        end
      end
      S_RD0:   state_d = S_RD1;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_RD3;
      S_RD3:   state_d = S_FLUSH;
      S_FLUSH: state_d = S_WRITE;
      S_WRITE: begin
        if (r_q == LAST && c_q == LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RD0;
          c_d     = c_q + OW'(1);
          if (c_q == LAST) r_d = r_q + OW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs decoded from the next state; the final compare feeds cdata_wr directly.
  always_comb begin
    tap_d      = 2'(state_d - S_RD0);
    busy_d     = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d     = (state_d == S_DONE);
    crd_d      = (state_d >= S_RD0) && (state_d <= S_RD3);
    cwr_d      = (state_d == S_WRITE);
    csel_d     = cwr_d ? CSEL_L1 : CSEL_L0;
    caddr_rd_d = caddr_rd_q;
    caddr_wr_d = caddr_wr_q;
    cdata_wr_d = cdata_wr_q;
    if (crd_d) caddr_rd_d = AW'({r_d, tap_d[1], c_d, tap_d[0]});
    if (cwr_d) begin
      caddr_wr_d = AW'({r_q, c_q});
      cdata_wr_d = umax(acc_max, bus.cdata_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      r_q        <= '0;
      c_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crd_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= 1'b0;
      caddr_rd_q <= '0;
      caddr_wr_q <= '0;
      cdata_wr_q <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      c_q        <= c_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crd_q      <= crd_d;
      cwr_q      <= cwr_d;
      csel_q     <= csel_d;
      caddr_rd_q <= caddr_rd_d;
      caddr_wr_q <= caddr_wr_d;
      cdata_wr_q <= cdata_wr_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.crd      = crd_q;
  assign bus.caddr_rd = caddr_rd_q;
  assign bus.cwr      = cwr_q;
  assign bus.caddr_wr = caddr_wr_q;
  assign bus.cdata_wr = cdata_wr_q;
  assign bus.csel     = csel_q;

endmodule
